aes_sub_bytes_unit: RTL and testbench
=====================================

Name: aes_sub_bytes_unit

Overview:
Registered AES byte-substitution stage. It applies either the forward S-box (SubBytes) or the inverse S-box (InvSubBytes) to all 16 bytes of a 128-bit AES state. It sits in the AES round datapath between AddRoundKey and ShiftRows, with the mode selected per transfer. It provides the SubByte and InvSubByte functions behind one clocked interface with a 1-cycle latency.

Parameters:
None. Data width is fixed at 128 bits (16 bytes). The S-box contents are fixed by FIPS-197.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_data/inv are valid this cycle
inv  input  1  0 = forward S-box (SubBytes); 1 = inverse S-box (InvSubBytes)
in_data  input  128  AES state in
out_valid  output  1  out_data holds a new result
out_data  output  128  substituted state

Behaviour:
- Byte mapping: byte k = bits [8k+7:8k], k = 0..15.
  - Forward mode: out byte k = SBOX(in byte k).
  - Inverse mode: out byte k = INV_SBOX(in byte k).
  - Bytes are independent. There is no permutation or mixing between bytes.
- SBOX and INV_SBOX are the exact FIPS-197 tables. Each may be a 256-entry case table or GF(2^8) inverse plus affine logic; either is acceptable.
  - For all x: INV_SBOX(SBOX(x)) = x.
  - Anchor values: SBOX(00)=63, SBOX(01)=7C, SBOX(53)=ED, SBOX(FF)=16.
- Datapath: the substitution is combinational from in_data/inv, followed by a single output register stage.
- Latency: a sample taken at rising edge N (in_valid=1) appears on out_data with out_valid=1 after edge N, i.e. during cycle N+1.
- Throughput: one state per cycle. Back-to-back in_valid is allowed, and there are no stalls or backpressure.
- in_valid=0 at an edge:
  - out_valid goes to 0.
  - out_data holds its previous value and is not updated.
- Mode: inv is sampled together with in_data at the same edge. Switching inv between consecutive valid cycles is allowed; each result uses its own sampled mode.
- Reset: while rst_n=0, out_valid=0 and out_data=128'h0, asynchronously and regardless of clk.
  - Reset asserted mid-stream discards any in-flight result.
  - The first edge after rst_n rises behaves normally.
- X/undefined inputs while in_valid=0 must not propagate into out_data.

Test Plan:
1. Reset: hold rst_n=0 with random inputs -> out_valid=0, out_data=0. Deassert, apply in_valid=1, inv=0, in_data=0 -> next cycle out_data=63636363636363636363636363636363, out_valid=1.
2. Forward FIPS-197 vector: inv=0, in_data=00102030405060708090a0b0c0d0e0f0 -> out_data=63cab7040953d051cd60e0e7ba70e18c.
3. Inverse vector: inv=1, in_data=63cab7040953d051cd60e0e7ba70e18c -> out_data=00102030405060708090a0b0c0d0e0f0. Also inv=1, all bytes 16 -> all bytes FF.
4. Exhaustive table check:
   - Sweep all 256 byte values replicated in every byte lane, in both modes; compare against reference tables.
   - Verify INV_SBOX(SBOX(x))=x through a two-pass loopback.
   - Apply 20+ random 128-bit states per mode against a golden model.
5. Streaming and mode switching:
   - Back-to-back valid inputs alternating inv=0/1 -> each output matches its own mode, one cycle later, with no bubbles.
   - Insert in_valid=0 -> out_valid=0 and out_data held.
6. Mid-stream reset: assert rst_n=0 asynchronously between edges during streaming -> out_valid/out_data clear immediately, and no stale result appears after release.

Source files
------------

// File: rtl/aes_sub_bytes_unit.sv
// Registered AES SubBytes / InvSubBytes stage: 16 independent byte lanes
// substituted combinationally, then captured in one output register.
module aes_sub_bytes_unit (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic         inv,
  input  logic [127:0] in_data,
  output logic         out_valid,
  output logic [127:0] out_data
);

  // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    return gf_mul(x252, x2);
  endfunction

  function automatic logic [7:0] fwd_affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] s);
    return {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
  endfunction

  // One inverter serves both directions: forward is affine(inv(x)),
  // inverse is inv(inv_affine(x)).
  function automatic logic [7:0] sub_byte(input logic [7:0] x, input logic mode);
    logic [7:0] pre;
    logic [7:0] g;
    pre = mode ? inv_affine(x) : x;
    g   = gf_inv(pre);
    return mode ? g : fwd_affine(g);
  endfunction

  logic [127:0] sub_data;

  always_comb begin
    sub_data = '0;
    for (int k = 0; k < 16; k++) begin
      sub_data[8*k +: 8] = sub_byte(in_data[8*k +: 8], inv);
    end
  end

  // out_data only loads on valid, so idle-cycle garbage never reaches it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) out_data <= sub_data;
    end
  end

endmodule

// File: tb/tb_aes_sub_bytes_unit.sv
// Self-checking bench for aes_sub_bytes_unit: FIPS-197 table reference model,
// directed vectors, exhaustive lane sweep, random streams and reset cases.
module tb_aes_sub_bytes_unit;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         inv;
  logic [127:0] in_data;
  logic         out_valid;
  logic [127:0] out_data;

  int checks = 0;
  int errors = 0;

  logic [127:0] exp_q[$];
  logic [127:0] held;

  logic [0:255][7:0] sbox_flat;
  logic [7:0]        sbox_t[256];
  logic [7:0]        inv_t[256];

  aes_sub_bytes_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .inv       (inv),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: table lookup per byte lane
  function automatic logic [127:0] model(input logic mode, input logic [127:0] d);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      r[8*k +: 8] = mode ? inv_t[d[8*k +: 8]] : sbox_t[d[8*k +: 8]];
    end
    return r;
  endfunction

  function automatic logic [127:0] rand_state();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver: presents one cycle of inputs, then checks the registered result.
  task automatic cycle(input logic v, input logic m, input logic [127:0] d, input string tag);
    in_valid = v;
    inv      = m;
    in_data  = d;
    if (v) exp_q.push_back(model(m, d));
    @(posedge clk);
    #1;
    chk({tag, "_valid"}, {127'b0, out_valid}, {127'b0, v});
    if (v) held = exp_q.pop_front();
    chk({tag, "_data"}, out_data, held);
  endtask

  logic [127:0] st;
  logic [127:0] fwd_out;

  initial begin
    sbox_flat = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    for (int i = 0; i < 256; i++) sbox_t[i] = sbox_flat[i];
    for (int i = 0; i < 256; i++) inv_t[sbox_t[i]] = i[7:0];

    // Reset held low with random inputs
    rst_n = 1'b0; held = '0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; inv = $urandom_range(0, 1); in_data = rand_state();
      @(posedge clk); #1;
      chk("rst_valid", {127'b0, out_valid}, 128'h0);
      chk("rst_data", out_data, 128'h0);
    end
    rst_n = 1'b1;

    cycle(1'b1, 1'b0, 128'h0, "first_after_rst");
    chk("anchor_00", held, {16{8'h63}});
    cycle(1'b1, 1'b0, {{15{8'h53}}, 8'h01}, "anchor_53_01");
    chk("anchor_53_01_const", out_data, {{15{8'hed}}, 8'h7c});
    cycle(1'b1, 1'b0, {16{8'hff}}, "anchor_ff");
    chk("anchor_ff_const", out_data, {16{8'h16}});

    // FIPS-197 vectors
    cycle(1'b1, 1'b0, 128'h00102030405060708090a0b0c0d0e0f0, "fips_fwd");
    chk("fips_fwd_const", out_data, 128'h63cab7040953d051cd60e0e7ba70e18c);
    cycle(1'b1, 1'b1, 128'h63cab7040953d051cd60e0e7ba70e18c, "fips_inv");
    chk("fips_inv_const", out_data, 128'h00102030405060708090a0b0c0d0e0f0);
    cycle(1'b1, 1'b1, {16{8'h16}}, "inv_16");
    chk("inv_16_const", out_data, {16{8'hff}});

    // Exhaustive lane sweep, both modes, back to back
    for (int m = 0; m < 2; m++) begin
      for (int b = 0; b < 256; b++) begin
        cycle(1'b1, m[0], {16{b[7:0]}}, m == 0 ? "sweep_fwd" : "sweep_inv");
      end
    end

    // Two-pass loopback: inverse of forward output restores the input
    for (int i = 0; i < 16; i++) begin
      st = rand_state();
      cycle(1'b1, 1'b0, st, "loop_fwd");
      fwd_out = out_data;
      cycle(1'b1, 1'b1, fwd_out, "loop_inv");
      chk("loop_restore", out_data, st);
    end

    // Random streaming with alternating modes
    for (int i = 0; i < 48; i++) begin
      cycle(1'b1, i[0], rand_state(), "stream_alt");
    end

    // Idle cycles hold data, including undefined idle inputs
    cycle(1'b0, 1'b0, rand_state(), "idle_hold");
    cycle(1'b0, 1'b1, 'x, "idle_x");
    cycle(1'b1, 1'b1, rand_state(), "after_idle");

    // Random valid gaps and modes
    for (int i = 0; i < 64; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1), rand_state(), "rand_mix");
    end

    // Mid-stream asynchronous reset between edges
    cycle(1'b1, 1'b0, rand_state(), "pre_mid_rst");
    in_valid = 1'b1; inv = 1'b1; in_data = rand_state();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {127'b0, out_valid}, 128'h0);
    chk("mid_rst_data", out_data, 128'h0);
    held = '0;
    exp_q.delete();
    @(posedge clk); #1;
    chk("mid_rst_hold_valid", {127'b0, out_valid}, 128'h0);
    chk("mid_rst_hold_data", out_data, 128'h0);
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, rand_state(), "post_rst_no_stale");
    cycle(1'b1, 1'b0, 128'h00102030405060708090a0b0c0d0e0f0, "post_rst_fwd");
    chk("post_rst_fwd_const", out_data, 128'h63cab7040953d051cd60e0e7ba70e18c);

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
